// File: rtl/render_frame_writer.sv
// Packs renderer pixels to RGB444 and writes them into a ping-pong frame buffer;
// banks swap only on a VGA new-frame pulse after a completed render frame.
module render_frame_writer #(
  parameter int unsigned START_X       = 390,
  parameter int unsigned START_Y       = 390,
  parameter int unsigned END_X         = 634,
  parameter int unsigned END_Y         = 765,
  parameter int unsigned REGION_DIVIDE = 530,
  parameter int unsigned X_SHIFT       = 2,
  parameter int unsigned ADDR_W        = 18
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [23:0]       pix_tdata,
  input  logic [10:0]       pix_hcount,
  input  logic [9:0]        pix_vcount,
  input  logic              pix_tvalid,
  output logic              pix_tready,
  input  logic              nf_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              rd_bank,
  output logic              frame_done,
  output logic [7:0]        frame_count
);

  localparam logic [ADDR_W-1:0] W_C       = ADDR_W'(END_X - START_X);
  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'((END_X - START_X) * (END_Y - START_Y));

  typedef enum logic {
    WRITING   = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;

  logic [ADDR_W-1:0] hc, vc, shift, x_off, y_off, base;
  logic              in_range, is_last, accept;

  // Only the top nibble of each colour channel is stored.
  logic unused_pix_bits;
  assign unused_pix_bits = ^{pix_tdata[19:16], pix_tdata[11:8], pix_tdata[3:0]};

  assign pix_tready = (state_q == WRITING) && !rst_in;

  always_comb begin
    hc       = ADDR_W'(pix_hcount);
    vc       = ADDR_W'(pix_vcount);
    shift    = (vc < ADDR_W'(REGION_DIVIDE)) ? ADDR_W'(X_SHIFT) : '0;
    // Subtractions below are only consumed when in_range holds, so they never underflow in use.
    in_range = (hc >= ADDR_W'(START_X) + shift) && (hc < ADDR_W'(END_X)) &&
               (vc >= ADDR_W'(START_Y)) && (vc < ADDR_W'(END_Y));
    x_off    = hc - ADDR_W'(START_X) - shift;
    y_off    = vc - ADDR_W'(START_Y);
    base     = wr_bank_q ? FRAME_PIX : '0;
    is_last  = (pix_hcount == 11'(END_X - 1)) && (pix_vcount == 10'(END_Y - 1));
    accept   = pix_tvalid && pix_tready;
  end

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_count_d = frame_count_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    case (state_q)
      WRITING: begin
        if (accept) begin
          if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base + y_off * W_C + x_off;
            wr_data_d = {pix_tdata[23:20], pix_tdata[15:12], pix_tdata[7:4]};
          end
          if (is_last) begin
            frame_done_d = 1'b1;
            state_d      = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (nf_in) begin
          rd_bank_d     = wr_bank_q;
          wr_bank_d     = ~wr_bank_q;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = WRITING;
        end
      end
      default: state_d = WRITING;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= WRITING;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      frame_count_q <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_count_q <= frame_count_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_bank     = rd_bank_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_render_frame_writer.sv
// Randomised bench for render_frame_writer: behavioural model checked every cycle
// plus literal expectations for the key address/swap scenarios.
module tb_render_frame_writer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [23:0] pix_tdata;
  logic [10:0] pix_hcount;
  logic [9:0]  pix_vcount;
  logic        pix_tvalid;
  logic        pix_tready;
  logic        nf_in;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [11:0] wr_data;
  logic        rd_bank;
  logic        frame_done;
  logic [7:0]  frame_count;

  render_frame_writer #(
    .START_X(390), .START_Y(390), .END_X(634), .END_Y(765),
    .REGION_DIVIDE(530), .X_SHIFT(2), .ADDR_W(18)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pix_tdata(pix_tdata),
    .pix_hcount(pix_hcount), .pix_vcount(pix_vcount), .pix_tvalid(pix_tvalid),
    .pix_tready(pix_tready), .nf_in(nf_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the registered outputs must be after each edge.
  bit m_writing = 1'b1;
  int m_wb = 0, m_rb = 1, m_fc = 0;
  bit e_wr_en = 1'b0, e_fd = 1'b0, e_addr_chk = 1'b0;
  int e_addr = 0, e_data = 0;
  int mh, mv, msh;
  bit started = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_writing = 1'b1; m_wb = 0; m_rb = 1; m_fc = 0;
      e_wr_en = 1'b0; e_fd = 1'b0; e_addr = 0; e_data = 0; e_addr_chk = 1'b1;
    end else begin
      e_wr_en = 1'b0; e_fd = 1'b0; e_addr_chk = 1'b0;
      if (m_writing) begin
        if (pix_tvalid) begin
          mh  = int'(pix_hcount);
          mv  = int'(pix_vcount);
          msh = (mv < 530) ? 2 : 0;
          if (mh >= 390 + msh && mh < 634 && mv >= 390 && mv < 765) begin
            e_wr_en    = 1'b1;
            e_addr_chk = 1'b1;
            e_addr     = m_wb * 91500 + (mv - 390) * 244 + (mh - 390 - msh);
            e_data     = int'({pix_tdata[23:20], pix_tdata[15:12], pix_tdata[7:4]});
          end
          if (mh == 633 && mv == 764) begin
            e_fd      = 1'b1;
            m_writing = 1'b0;
          end
        end
      end else if (nf_in) begin
        m_rb = m_wb;
        m_wb = 1 - m_wb;
        m_fc = (m_fc + 1) % 256;
        m_writing = 1'b1;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk_in) begin
    if (started) begin
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      if (e_addr_chk) begin
        chk("wr_addr", 32'(wr_addr), e_addr);
        chk("wr_data", 32'(wr_data), e_data);
      end
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("rd_bank", 32'(rd_bank), m_rb);
      chk("frame_count", 32'(frame_count), m_fc);
      chk("pix_tready", 32'(pix_tready), 32'(m_writing && !rst_in));
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int h, input int v, input logic [23:0] d, input bit nf);
    pix_hcount = 11'(h);
    pix_vcount = 10'(v);
    pix_tdata  = d;
    pix_tvalid = 1'b1;
    nf_in      = nf;
    step();
    pix_tvalid = 1'b0;
    nf_in      = 1'b0;
  endtask

  // Idle cycle with the final-pixel coordinates on the bus but no valid.
  task automatic gap();
    pix_hcount = 11'd633;
    pix_vcount = 10'd764;
    pix_tdata  = 24'($urandom);
    pix_tvalid = 1'b0;
    nf_in      = ($urandom_range(0, 9) == 0);
    step();
    nf_in = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_tvalid = 1'b0;
    nf_in      = 1'b0;
    repeat (n) step();
  endtask

  task automatic nf_pulse();
    nf_in = 1'b1;
    step();
    nf_in = 1'b0;
  endtask

  task automatic stream_frame(input bit last_nf);
    int rows[5];
    int hend;
    rows = '{390, 391, 529, 530, 764};
    for (int r = 0; r < 5; r++) begin
      hend = (rows[r] == 764) ? 632 : 637;
      for (int h = 386; h <= hend; h++) begin
        if ($urandom_range(0, 3) == 0) gap();
        send(h, rows[r], 24'($urandom), (rows[r] != 764) && ($urandom_range(0, 29) == 0));
      end
    end
    send(633, 764, 24'($urandom), last_nf);
  endtask

  initial begin
    int h, v;
    rst_in = 1'b1; pix_tdata = '0; pix_hcount = '0; pix_vcount = '0;
    pix_tvalid = 1'b0; nf_in = 1'b0;
    repeat (3) step();
    chk("reset wr_en", 32'(wr_en), 0);
    chk("reset wr_addr", 32'(wr_addr), 0);
    chk("reset rd_bank", 32'(rd_bank), 1);
    chk("reset frame_count", 32'(frame_count), 0);
    chk("reset pix_tready", 32'(pix_tready), 0);
    rst_in = 1'b0;
    step();
    chk("tready after reset", 32'(pix_tready), 1);

    send(392, 390, 24'hFF8040, 1'b0);
    chk("first pixel wr_en", 32'(wr_en), 1);
    chk("first pixel addr", 32'(wr_addr), 0);
    chk("first pixel data", 32'(wr_data), 32'hF84);
    send(390, 390, 24'hABCDEF, 1'b0);
    chk("shifted-out drop wr_en", 32'(wr_en), 0);
    send(390, 530, 24'h0F0F0F, 1'b0);
    chk("unshifted row addr", 32'(wr_addr), 34160);
    send(392, 400, 24'h123456, 1'b0);
    chk("cyl addr", 32'(wr_addr), 2440);
    chk("cyl data", 32'(wr_data), 32'h135);
    send(391, 400, 24'h654321, 1'b0);
    chk("cyl drop wr_en", 32'(wr_en), 0);
    chk("cyl drop tready", 32'(pix_tready), 1);

    stream_frame(1'b0);
    chk("last frame_done", 32'(frame_done), 1);
    chk("last addr", 32'(wr_addr), 91499);
    chk("wait tready", 32'(pix_tready), 0);
    chk("wait rd_bank", 32'(rd_bank), 1);
    idle(1);
    chk("frame_done pulse", 32'(frame_done), 0);
    idle(5);
    nf_pulse();
    chk("swap rd_bank", 32'(rd_bank), 0);
    chk("swap frame_count", 32'(frame_count), 1);
    chk("swap tready", 32'(pix_tready), 1);
    send(392, 390, 24'h102030, 1'b0);
    chk("bank1 first addr", 32'(wr_addr), 91500);
    send(633, 530, 24'h405060, 1'b0);
    chk("bank1 row530 end", 32'(wr_addr), 125903);
    send(392, 529, 24'h708090, 1'b0);
    chk("bank1 row529 start", 32'(wr_addr), 125416);

    // Mid-frame reset while the final pixel is presented.
    pix_hcount = 11'd633; pix_vcount = 10'd764; pix_tvalid = 1'b1; rst_in = 1'b1;
    step();
    rst_in = 1'b0; pix_tvalid = 1'b0;
    chk("midreset frame_done", 32'(frame_done), 0);
    chk("midreset rd_bank", 32'(rd_bank), 1);
    chk("midreset frame_count", 32'(frame_count), 0);
    step();
    chk("post reset frame_done", 32'(frame_done), 0);
    send(392, 390, 24'hFFFFFF, 1'b0);
    chk("restart addr", 32'(wr_addr), 0);

    stream_frame(1'b1);
    chk("nf-with-last frame_done", 32'(frame_done), 1);
    chk("nf-with-last rd_bank", 32'(rd_bank), 1);
    idle(100);
    chk("held rd_bank", 32'(rd_bank), 1);
    chk("held frame_count", 32'(frame_count), 0);
    nf_pulse();
    chk("late swap frame_count", 32'(frame_count), 1);
    chk("late swap rd_bank", 32'(rd_bank), 0);

    stream_frame(1'b0);
    nf_pulse();
    chk("next-cycle swap count", 32'(frame_count), 2);
    chk("next-cycle swap rd_bank", 32'(rd_bank), 1);
    send(392, 390, 24'h00FF00, 1'b0);
    chk("bank0 again addr", 32'(wr_addr), 0);

    repeat (2) begin
      stream_frame(1'($urandom_range(0, 1)));
      idle($urandom_range(0, 5));
      nf_pulse();
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 2047);
        v = $urandom_range(0, 1023);
      end else begin
        h = $urandom_range(380, 640);
        v = $urandom_range(380, 770);
      end
      if (h == 633 && v == 764 && $urandom_range(0, 3) != 0) h = 632;
      if ($urandom_range(0, 199) == 0) begin h = 633; v = 764; end
      pix_hcount = 11'(h);
      pix_vcount = 10'(v);
      pix_tdata  = 24'($urandom);
      pix_tvalid = ($urandom_range(0, 3) != 0);
      nf_in      = ($urandom_range(0, 19) == 0);
      step();
    end
    pix_tvalid = 1'b0; nf_in = 1'b0;

    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    repeat (260) begin
      send(633, 764, 24'($urandom), 1'b0);
      idle($urandom_range(0, 2));
      nf_pulse();
    end
    chk("wrap frame_count", 32'(frame_count), 4);
    chk("wrap rd_bank", 32'(rd_bank), 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
